// File: rtl/weight_row_streamer.sv
// Latches one NEURON_NUM x NEURON_NUM weight matrix with its layer tag, then replays it
// one row per handshake; row r carries the weights feeding neuron r.
module weight_row_streamer #(
    parameter int NEURON_NUM        = 4,
    parameter int WEIGHT_CELL_WIDTH = 16,
    parameter int LAYER_ADDR_WIDTH  = 2,
    parameter int ROW_ADDR_WIDTH    = 2
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [LAYER_ADDR_WIDTH-1:0]                         layer,
    input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]  w,
    input  logic                                                w_valid,
    output logic                                                w_ready,
    output logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]             row,
    output logic [ROW_ADDR_WIDTH-1:0]                           row_idx,
    output logic [LAYER_ADDR_WIDTH-1:0]                         row_layer,
    output logic                                                row_last,
    output logic                                                row_valid,
    input  logic                                                row_ready,
    output logic                                                busy
);

    localparam int ROW_W = NEURON_NUM * WEIGHT_CELL_WIDTH;
    localparam int MAT_W = NEURON_NUM * ROW_W;
    localparam int IDX_SLOTS = 2 ** ROW_ADDR_WIDTH;
    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_IDX = ROW_ADDR_WIDTH'(NEURON_NUM - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                          state_reg, state_next;
    logic [MAT_W-1:0]                matrix_reg;
    logic [LAYER_ADDR_WIDTH-1:0]     layer_reg;
    logic [ROW_ADDR_WIDTH-1:0]       idx_reg, idx_next, idx_inc;
    logic [ROW_W-1:0]                row_reg, row_next;
    logic                            last_reg, last_next;
    logic                            load_matrix;

    // Row slices padded to the full index range so any idx value selects a defined row.
    logic [ROW_W-1:0] rows [IDX_SLOTS];

    generate
        for (genvar gi = 0; gi < IDX_SLOTS; gi++) begin : g_rows
            if (gi < NEURON_NUM) begin : g_live
                assign rows[gi] = matrix_reg[gi*ROW_W +: ROW_W];
            end else begin : g_pad
                assign rows[gi] = '0;
            end
        end
    endgenerate

    assign idx_inc = idx_reg + ROW_ADDR_WIDTH'(1);

    assign w_ready   = (state_reg == IDLE) && rst;
    assign row_valid = (state_reg == STREAM);
    assign busy      = (state_reg == STREAM);
    assign row       = row_reg;
    assign row_idx   = idx_reg;
    assign row_layer = layer_reg;
    assign row_last  = last_reg;

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        row_next    = row_reg;
        last_next   = last_reg;
        load_matrix = 1'b0;
        case (state_reg)
            IDLE: begin
                if (w_valid && w_ready) begin
                    load_matrix = 1'b1;
                    state_next  = STREAM;
                    idx_next    = '0;
                    // Row 0 comes straight from the incoming bus so it is valid next cycle.
                    row_next    = w[ROW_W-1:0];
                    last_next   = (LAST_IDX == '0);
                end
            end
            STREAM: begin
                if (row_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = IDLE;
                    end else begin
                        idx_next  = idx_inc;
                        row_next  = rows[idx_inc];
                        last_next = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            matrix_reg <= '0;
            layer_reg  <= '0;
            idx_reg    <= '0;
            row_reg    <= '0;
            last_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            row_reg   <= row_next;
            last_reg  <= last_next;
            if (load_matrix) begin
                matrix_reg <= w;
                layer_reg  <= layer;
            end
        end
    end

endmodule

// File: tb/tb_weight_row_streamer.sv
// Directed bench for weight_row_streamer: expected rows are queued when a matrix is driven
// and compared against each presented row at the negative clock edge.
module tb_weight_row_streamer;

    localparam int N  = 4;
    localparam int WC = 16;

    typedef struct packed {
        logic [N*WC-1:0] row;
        logic [1:0]      idx;
        logic [1:0]      layer;
        logic            last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        layer;
    logic [N*N*WC-1:0] w;
    logic              w_valid;
    logic              w_ready;
    logic [N*WC-1:0]   row;
    logic [1:0]        row_idx;
    logic [1:0]        row_layer;
    logic              row_last;
    logic              row_valid;
    logic              row_ready;
    logic              busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    weight_row_streamer #(
        .NEURON_NUM(N),
        .WEIGHT_CELL_WIDTH(WC),
        .LAYER_ADDR_WIDTH(2),
        .ROW_ADDR_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .layer(layer),
        .w(w),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .row(row),
        .row_idx(row_idx),
        .row_layer(row_layer),
        .row_last(row_last),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cell i of the driven matrix holds base+i+1.
    task automatic set_w(input int base, input int tag);
        for (int i = 0; i < N*N; i++) w[i*WC +: WC] = WC'(base + i + 1);
        layer = 2'(tag);
    endtask

    task automatic push_matrix(input int base, input int tag);
        exp_t e;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) e.row[c*WC +: WC] = WC'(base + r*N + c + 1);
            e.idx   = 2'(r);
            e.layer = 2'(tag);
            e.last  = (r == N-1);
            exp_q.push_back(e);
        end
    endtask

    // Every presented row must match the queue head; it is retired only on handshake,
    // so a stalled row is re-checked each cycle for stability.
    always @(negedge clk) begin
        if (rst && row_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_row observed idx=%0d row=%0h expected no row", row_idx, row);
            end else begin
                chk("row", 128'({row, row_idx, row_layer, row_last}), 128'(exp_q[0]));
                chk("busy_stream", 128'(busy), 128'(1));
                if (row_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; w_valid = 1'b0; row_ready = 1'b0; w = '0; layer = '0;

        // Reset
        tick(10);
        chk("rst_row_valid", 128'(row_valid), 128'(0));
        chk("rst_w_ready", 128'(w_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_row_idx", 128'(row_idx), 128'(0));
        rst = 1'b1;
        tick(1);
        chk("post_rst_w_ready", 128'(w_ready), 128'(1));
        chk("post_rst_row_valid", 128'(row_valid), 128'(0));
        $display("step reset done");

        // Basic streaming
        set_w(0, 2); w_valid = 1'b1; row_ready = 1'b1; push_matrix(0, 2);
        tick(1);
        w_valid = 1'b0;
        chk("basic_w_ready_stream", 128'(w_ready), 128'(0));
        chk("basic_busy", 128'(busy), 128'(1));
        tick(4);
        chk("basic_w_ready_after", 128'(w_ready), 128'(1));
        chk("basic_idle_valid", 128'(row_valid), 128'(0));
        chk("basic_drained", 128'(exp_q.size()), 128'(0));
        $display("step basic done");

        // Backpressure on row 1
        set_w(200, 1); w_valid = 1'b1; push_matrix(200, 1);
        tick(1);
        w_valid = 1'b0;
        tick(1);
        row_ready = 1'b0;
        tick(5);
        chk("bp_row_idx_held", 128'(row_idx), 128'(1));
        row_ready = 1'b1;
        tick(3);
        chk("bp_drained", 128'(exp_q.size()), 128'(0));
        chk("bp_idle_valid", 128'(row_valid), 128'(0));
        $display("step backpressure done");

        // Input isolation: second matrix held on the bus during STREAM
        set_w(300, 3); w_valid = 1'b1; push_matrix(300, 3); push_matrix(400, 0);
        tick(1);
        set_w(400, 0);
        chk("iso_w_ready_0", 128'(w_ready), 128'(0));
        tick(1);
        chk("iso_w_ready_1", 128'(w_ready), 128'(0));
        tick(3);
        chk("iso_w_ready_idle", 128'(w_ready), 128'(1));
        tick(1);
        w_valid = 1'b0;
        tick(4);
        chk("iso_drained", 128'(exp_q.size()), 128'(0));
        $display("step isolation done");

        // Back-to-back matrices with w_valid held: 8 rows within 10 cycles
        set_w(0, 0); w_valid = 1'b1; push_matrix(0, 0); push_matrix(100, 1);
        tick(1);
        set_w(100, 1);
        tick(9);
        w_valid = 1'b0;
        chk("b2b_drained", 128'(exp_q.size()), 128'(0));
        chk("b2b_idle_valid", 128'(row_valid), 128'(0));
        $display("step back_to_back done");

        // Reset in the middle of a stream
        set_w(500, 2); w_valid = 1'b1; push_matrix(500, 2);
        tick(1);
        w_valid = 1'b0;
        tick(2);
        chk("mid_row_idx", 128'(row_idx), 128'(2));
        rst = 1'b0;
        #1;
        chk("mid_rst_row_valid", 128'(row_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_w_ready", 128'(w_ready), 128'(0));
        exp_q.delete();
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("mid_post_w_ready", 128'(w_ready), 128'(1));
        chk("mid_post_row_valid", 128'(row_valid), 128'(0));
        set_w(600, 1); w_valid = 1'b1; push_matrix(600, 1);
        tick(1);
        w_valid = 1'b0;
        chk("mid_restart_idx", 128'(row_idx), 128'(0));
        tick(4);
        chk("mid_restart_drained", 128'(exp_q.size()), 128'(0));
        $display("step reset_mid_stream done");

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
